cmd_rx_port: RTL and testbench
==============================

# cmd_rx_port

Port-mapped receive buffer that sits directly upstream of the command-control processor. It accepts a byte stream from the serial receiver, holds the bytes in a FIFO, and presents data and status on the processor input bus. It raises a level interrupt while unread data is waiting, and the firmware acknowledges and drains it with INPUT instructions.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- DATA_PORT, 8'h00: reading pops one byte. Writes to this port are ignored.
- STATUS_PORT, 8'h01: read-only status byte.
- COUNT_PORT, 8'h02: read-only occupancy, zero-extended to 8 bits.
- CTRL_PORT, 8'h03: write-only control byte. Reads return 8'h00.

- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high; one clock domain.
- rx_data  in  8  received byte.
- rx_valid  in  1  single-cycle push strobe for rx_data.
- port_id  in  8  processor port address.
- port_out  in  8  processor output data.
- write_strobe  in  1  processor OUTPUT strobe.
- read_strobe  in  1  processor INPUT strobe.
- interrupt_ack  in  1  processor interrupt acknowledge.
- port_in  out  8  registered read data to the processor in_port.
- interrupt  out  1  registered level interrupt request.
- overflow  out  1  sticky overflow flag, also mirrored in the status byte.

## Operation
- FIFO
  - Circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo depth.
  - Count is DEPTH_LOG2+1 bits wide, 0..2^DEPTH_LOG2.
  - empty = (count==0); full = (count==depth).
- push = rx_valid.
  - Accepted if not full, or if full and a pop occurs in the same cycle.
  - A rejected push drops the byte and sets overflow.
- pop = read_strobe & (port_id==DATA_PORT) & ~empty.
  - A pop on an empty FIFO changes nothing.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Status byte: bit0 = ~empty, bit1 = full, bit2 = overflow, bit3 = int_en, bits7:4 = 0.
- CTRL write, when write_strobe & (port_id==CTRL_PORT), decodes port_out as follows.
  - bit0 loads int_en.
  - bit1 = flush: pointers and count go to 0 and do not persist.
  - bit2 = clear overflow.
- Simultaneous events:
  - Flush in the same cycle as a push: flush wins, the byte is discarded, and overflow is not set.
  - Clear-overflow in the same cycle as a rejected push: overflow stays set.
- port_in is registered every cycle as a mux on port_id: data = mem[rd_ptr], status, count, and 8'h00 for any other port.
- interrupt register next-state = int_en & ~empty & ~interrupt_ack.
  - interrupt_ack forces at least one low cycle.
  - interrupt re-asserts while bytes remain (level semantics).
- Reset mid-operation clears the FIFO, int_en, overflow, port_in and interrupt immediately, without waiting for a clock edge.

## Timing
- Reset values: port_in = 8'h00, interrupt = 0, overflow = 0, int_en = 0, count = 0, pointers = 0.
- Push at edge N: count and status reflect the byte after edge N; port_in shows the new status after edge N+1.
- interrupt rises after edge N+1 when int_en=1.
- Processor INPUT cycle:
  - port_id is stable for 2 cycles; port_in is valid from the second cycle.
  - read_strobe occurs in the second cycle, and the processor captures port_in at that same edge.
  - The pop advances rd_ptr at that same edge, so the captured byte is the pre-pop head.
- A back-to-back INPUT on DATA_PORT returns successive bytes with no bubble required.
- CTRL effects are visible one edge after the write_strobe cycle.
- There is no combinational path from any input to any output.

## Test plan
- Reset, then read STATUS_PORT → 8'h00; read COUNT_PORT → 8'h00; interrupt = 0.
- Push 8'hA5, 8'h3C, then read DATA_PORT twice → 8'hA5 then 8'h3C; the following status read → 8'h00.
- Write CTRL 8'h01, then push one byte → interrupt high two edges after the push.
  - Pulse interrupt_ack → interrupt low for ≥1 cycle, then high again.
  - Pop the byte → interrupt low and stays low.
- Push 17 bytes → COUNT = 8'h10, status = 8'h07 (overflow set, byte 17 lost).
  - Write CTRL 8'h04 → status = 8'h03.
- Fill 16 bytes, then push and pop in the same cycle → count stays 16, no overflow, the pushed byte is read last (wrap-around check).
- Push 5 bytes, then write CTRL 8'h02 together with an rx_valid in the same cycle → count = 0, overflow = 0.
  - Assert reset mid-stream with bytes queued → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cmd_rx_port_if.sv
// Processor-side port bus plus the serial receive stream feeding cmd_rx_port.
// master = processor/receiver side, slave = the receive buffer itself.
interface cmd_rx_port_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] port_id;
  logic [7:0] port_out;
  logic       write_strobe;
  logic       read_strobe;
  logic       interrupt_ack;
  logic [7:0] port_in;
  logic       interrupt;
  logic       overflow;

  modport master (
    output rx_data, rx_valid, port_id, port_out, write_strobe, read_strobe, interrupt_ack,
    input  port_in, interrupt, overflow
  );

  modport slave (
    input  rx_data, rx_valid, port_id, port_out, write_strobe, read_strobe, interrupt_ack,
    output port_in, interrupt, overflow
  );
endinterface

// File: rtl/cmd_rx_port.sv
// Port-mapped receive FIFO in front of the command-control processor: buffers
// serial bytes, exposes data/status/count ports and a level interrupt.
module cmd_rx_port #(
  parameter int         DEPTH_LOG2  = 4,
  parameter logic [7:0] DATA_PORT   = 8'h00,
  parameter logic [7:0] STATUS_PORT = 8'h01,
  parameter logic [7:0] COUNT_PORT  = 8'h02,
  parameter logic [7:0] CTRL_PORT   = 8'h03
) (
  input  logic         clk,
  input  logic         reset,
  cmd_rx_port_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr, rd_ptr, rd_ptr_inc;
  cnt_t       count;
  logic       overflow_q;
  logic       int_en;
  logic       interrupt_q;
  logic [7:0] port_in_q;

  logic       empty, full;
  logic       ctrl_wr, flush, clr_ovf;
  logic       pop, push_ok, push_rej;
  logic [7:0] status;
  logic [7:0] head_next;
  logic [7:0] port_in_next;

  always_comb begin
    empty      = (count == '0);
    full       = (count == FULL_COUNT);
    ctrl_wr    = bus.write_strobe && (bus.port_id == CTRL_PORT);
    flush      = ctrl_wr && bus.port_out[1];
    clr_ovf    = ctrl_wr && bus.port_out[2];
    pop        = bus.read_strobe && (bus.port_id == DATA_PORT) && !empty;
    // Flush dominates a concurrent push: the byte is discarded, not counted as overflow.
    push_ok    = bus.rx_valid && (!full || pop) && !flush;
    push_rej   = bus.rx_valid && full && !pop && !flush;
    rd_ptr_inc = rd_ptr + 1'b1;
    status     = {4'b0000, int_en, overflow_q, full, !empty};
  end

  // Look ahead to the post-pop head so back-to-back DATA reads need no bubble.
  // A byte pushed in the same cycle becomes that head when only one was queued.
  always_comb begin
    head_next = mem[rd_ptr];
    if (pop) begin
      if (push_ok && (wr_ptr == rd_ptr_inc)) head_next = bus.rx_data;
      else                                   head_next = mem[rd_ptr_inc];
    end
  end

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    port_in_next = 8'h00;
    case (bus.port_id)
      DATA_PORT:   port_in_next = head_next;
      STATUS_PORT: port_in_next = status;
      COUNT_PORT:  port_in_next = {{(7 - DEPTH_LOG2){1'b0}}, count};
      default:     port_in_next = 8'h00;
    endcase
  end

  // NOTE: the storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr_inc;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A rejected push outranks a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         overflow_q <= 1'b0;
    else if (push_rej) overflow_q <= 1'b1;
    else if (clr_ovf)  overflow_q <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        int_en <= 1'b0;
    else if (ctrl_wr) int_en <= bus.port_out[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interrupt_q <= 1'b0;
      port_in_q   <= 8'h00;
    end else begin
      interrupt_q <= int_en && !empty && !bus.interrupt_ack;
      port_in_q   <= port_in_next;
    end
  end

  assign bus.port_in   = port_in_q;
  assign bus.interrupt = interrupt_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cmd_rx_port.sv
// Randomized self-checking bench for cmd_rx_port against a queue-based model
// of the FIFO, status byte, overflow flag and interrupt level.
module tb_cmd_rx_port;

  localparam logic [7:0] P_DATA   = 8'h00;
  localparam logic [7:0] P_STATUS = 8'h01;
  localparam logic [7:0] P_COUNT  = 8'h02;
  localparam logic [7:0] P_CTRL   = 8'h03;
  localparam logic [7:0] P_IDLE   = 8'h40;
  localparam int         DEPTH    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmd_rx_port_if bus ();

  cmd_rx_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_int_en, m_irq;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {4'b0000, m_int_en, m_ovf, q.size() == DEPTH, q.size() != 0};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_int_en = 1'b0;
    m_irq    = 1'b0;
  endfunction

  // One clock cycle: drive, update the model with the block's rules, check flags.
  task automatic step(input bit rxv, input logic [7:0] rxd, input logic [7:0] pid,
                      input logic [7:0] pout, input bit ws, input bit rs, input bit ack);
    bit ctrl, do_flush, do_clr, do_pop, was_full, rejected, irq_next;
    bus.rx_valid      = rxv;
    bus.rx_data       = rxd;
    bus.port_id       = pid;
    bus.port_out      = pout;
    bus.write_strobe  = ws;
    bus.read_strobe   = rs;
    bus.interrupt_ack = ack;
    ctrl     = ws && (pid == P_CTRL);
    do_flush = ctrl && pout[1];
    do_clr   = ctrl && pout[2];
    do_pop   = rs && (pid == P_DATA) && (q.size() != 0);
    was_full = (q.size() == DEPTH);
    irq_next = m_int_en && (q.size() != 0) && !ack;
    rejected = 1'b0;
    @(posedge clk);
    if (do_flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (rxv) begin
        if (!was_full || do_pop) q.push_back(rxd);
        else rejected = 1'b1;
      end
    end
    if (rejected)    m_ovf = 1'b1;
    else if (do_clr) m_ovf = 1'b0;
    if (ctrl) m_int_en = pout[0];
    m_irq = irq_next;
    #1;
    check("interrupt", bus.interrupt, m_irq);
    check("overflow", bus.overflow, m_ovf);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, P_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, d, P_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ctrl_write(input logic [7:0] v);
    step(1'b0, 8'h00, P_CTRL, v, 1'b1, 1'b0, 1'b0);
  endtask

  // Two-cycle INPUT: port_id held, read_strobe in cycle two, port_in captured
  // just before that edge. Optional push rides along in the strobe cycle.
  task automatic do_input(input logic [7:0] pid, input bit rxv, input logic [7:0] rxd,
                          output logic [7:0] got);
    logic [7:0] exp;
    bit         known;
    step(1'b0, 8'h00, pid, 8'h00, 1'b0, 1'b0, 1'b0);
    known = 1'b1;
    case (pid)
      P_DATA: begin
        known = (q.size() != 0);
        exp   = known ? q[0] : 8'h00;
      end
      P_STATUS: exp = exp_status();
      P_COUNT:  exp = 8'(q.size());
      default:  exp = 8'h00;
    endcase
    got = bus.port_in;
    if (known) check($sformatf("port_in@%02h", pid), got, exp);
    step(rxv, rxd, pid, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [7:0] pid, output logic [7:0] got);
    do_input(pid, 1'b0, 8'h00, got);
  endtask

  logic [7:0] v;

  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.port_id = P_IDLE; bus.port_out = '0;
    bus.write_strobe = 1'b0; bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst port_in", bus.port_in, 8'h00);
    check("rst interrupt", bus.interrupt, 1'b0);
    check("rst overflow", bus.overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    rd(P_STATUS, v); check("reset status", v, 8'h00);
    rd(P_COUNT, v);  check("reset count", v, 8'h00);

    push(8'hA5); push(8'h3C);
    rd(P_DATA, v);   check("first byte", v, 8'hA5);
    rd(P_DATA, v);   check("second byte", v, 8'h3C);
    rd(P_STATUS, v); check("drained status", v, 8'h00);

    ctrl_write(8'h01);
    push(8'h11);
    idle();
    check("irq two edges after push", bus.interrupt, 1'b1);
    step(1'b0, 8'h00, P_IDLE, 8'h00, 1'b0, 1'b0, 1'b1);
    check("irq low after ack", bus.interrupt, 1'b0);
    idle();
    check("irq re-asserts", bus.interrupt, 1'b1);
    rd(P_DATA, v);   check("irq byte", v, 8'h11);
    repeat (3) idle();
    check("irq stays low", bus.interrupt, 1'b0);
    ctrl_write(8'h00);

    for (int i = 0; i < 17; i++) push(8'(i + 8'h20));
    rd(P_COUNT, v);  check("count full", v, 8'h10);
    rd(P_STATUS, v); check("status overflow", v, 8'h07);
    ctrl_write(8'h04);
    rd(P_STATUS, v); check("status ovf cleared", v, 8'h03);

    // Clear racing a rejected push: the loss must still be reported.
    step(1'b1, 8'hBB, P_CTRL, 8'h04, 1'b1, 1'b0, 1'b0);
    check("ovf survives clear", bus.overflow, 1'b1);
    ctrl_write(8'h04);

    do_input(P_DATA, 1'b1, 8'hEE, v);
    check("full push+pop head", v, 8'h20);
    rd(P_COUNT, v);  check("count after push+pop", v, 8'h10);
    for (int i = 0; i < DEPTH; i++) rd(P_DATA, v);
    check("wrapped byte last", v, 8'hEE);

    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    step(1'b1, 8'h77, P_CTRL, 8'h02, 1'b1, 1'b0, 1'b0);
    rd(P_COUNT, v);  check("count after flush", v, 8'h00);
    rd(P_STATUS, v); check("status after flush", v, 8'h00);

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r <= 4) begin
        step(1'b1, 8'($urandom), P_IDLE, 8'h00, 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
      end else if (r <= 6) begin
        rd(P_DATA, v);
      end else if (r == 7) begin
        rd(P_STATUS, v);
      end else if (r == 8) begin
        case ($urandom_range(0, 2))
          0:       rd(P_COUNT, v);
          1:       rd(P_CTRL, v);
          default: rd(8'h55, v);
        endcase
      end else if (r == 9) begin
        logic [7:0] c;
        c = 8'($urandom) & 8'h07;
        if ($urandom_range(0, 3) != 0) c[1] = 1'b0;
        ctrl_write(c);
      end else if (r == 10) begin
        do_input(P_DATA, 1'b1, 8'($urandom), v);
      end else begin
        step(1'b0, 8'h00, P_IDLE, 8'h00, 1'b0, 1'b0, 1'b1);
      end
    end

    ctrl_write(8'h00);
    ctrl_write(8'h02);
    ctrl_write(8'h01);
    push(8'h91); push(8'h92); push(8'h93);
    step(1'b0, 8'h00, P_STATUS, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, P_STATUS, 8'h00, 1'b0, 1'b0, 1'b0);
    check("pre-reset status", bus.port_in, 8'h09);
    check("pre-reset irq", bus.interrupt, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("async port_in", bus.port_in, 8'h00);
    check("async interrupt", bus.interrupt, 1'b0);
    check("async overflow", bus.overflow, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    rd(P_COUNT, v);  check("post-reset count", v, 8'h00);
    rd(P_STATUS, v); check("post-reset status", v, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
